tom_key_decoder: RTL and testbench

//  - Upstream stage of Tom's position controller: turns the PS/2 scan-code byte stream
//    (Set 2, from the PS/2 byte receiver) into held-key movement flags.
//  - Parses make, break (F0) and extended (E0) prefixes and tracks which keys are held.
//  - Resolves left/right conflicts; feeds move/jump/crouch flags to the Tom control FSM.

---
 rtl/tom_key_decoder.sv | 188 ++++++++++++++++++
 tb/tb_tom_key_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tom_key_decoder.sv
// ---------------------------------------------------------------------------
// tom_key_decoder
//   Turns the PS/2 Set 2 scan-code byte stream into held-key movement flags
//   for Tom's control FSM. Parses make, break (F0) and extended (E0)
//   prefixes, tracks which keys are held, and resolves left/right conflicts
//   in favour of the most recently pressed direction.
//
//   Optional feature: define KEY_TIMEOUT_EN to force-release all held keys
//   after TIMEOUT_CYCLES cycles with no incoming byte. This recovers from
//   lost break codes. Without the macro, TIMEOUT_CYCLES is only range-checked.
//
// Ports
//   clk         in   1  system clock
//   rst         in   1  synchronous, active-high reset
//   rx_data     in   8  scan-code byte from the PS/2 receiver
//   rx_valid    in   1  one-cycle strobe qualifying rx_data
//   move_left   out  1  resolved left command
//   move_right  out  1  resolved right command
//   jump        out  1  up arrow or space held
//   crouch      out  1  down arrow held
//   keys_held   out  4  raw held flags {down, up/space, right, left}
//
// Handshake: rx_valid is a one-cycle strobe with no backpressure. Every byte
// presented with rx_valid=1 is consumed on that clock edge.
// ---------------------------------------------------------------------------
module tom_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       crouch,
    output logic [3:0] keys_held
);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_SPACE = 8'h29;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t state;

    // Held flags. The two up sources are kept apart so releasing one does
    // not drop jump while the other is still down.
    logic left_h;
    logic right_h;
    logic up_ext_h;
    logic up_space_h;
    logic down_h;
    logic last_right;   // 0: left was the most recent press, 1: right
    logic any_held;
    logic timeout_hit;

    assign any_held = left_h | right_h | up_ext_h | up_space_h | down_h;

`ifdef KEY_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (rx_valid) begin
            idle_cnt <= '0;
        end else if (idle_cnt != T_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // The expiry edge is the one on which the count reaches TIMEOUT_CYCLES.
    // A byte arriving on that same edge takes priority.
    assign timeout_hit = !rx_valid && any_held && (idle_cnt >= T_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Parser FSM and held-key tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            left_h     <= 1'b0;
            right_h    <= 1'b0;
            up_ext_h   <= 1'b0;
            up_space_h <= 1'b0;
            down_h     <= 1'b0;
            last_right <= 1'b0;
        end else if (timeout_hit) begin
            state      <= IDLE;
            left_h     <= 1'b0;
            right_h    <= 1'b0;
            up_ext_h   <= 1'b0;
            up_space_h <= 1'b0;
            down_h     <= 1'b0;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == CODE_EXT) begin
                        state <= EXT;
                    end else if (rx_data == CODE_BRK) begin
                        state <= BRK;
                    end else if (rx_data == CODE_SPACE) begin
                        up_space_h <= 1'b1;
                    end
                end
                EXT: begin
                    state <= IDLE;
                    case (rx_data)
                        CODE_EXT:   state <= EXT;
                        CODE_BRK:   state <= EXT_BRK;
                        CODE_LEFT: begin
                            // Typematic repeats must not steal priority.
                            if (!left_h) last_right <= 1'b0;
                            left_h <= 1'b1;
                        end
                        CODE_RIGHT: begin
                            if (!right_h) last_right <= 1'b1;
                            right_h <= 1'b1;
                        end
                        CODE_UP:    up_ext_h <= 1'b1;
                        CODE_DOWN:  down_h   <= 1'b1;
                        default:    ;
                    endcase
                end
                BRK: begin
                    state <= IDLE;
                    case (rx_data)
                        CODE_EXT:   state <= EXT;
                        CODE_BRK:   state <= BRK;
                        CODE_SPACE: up_space_h <= 1'b0;
                        default:    ;
                    endcase
                end
                EXT_BRK: begin
                    state <= IDLE;
                    case (rx_data)
                        CODE_EXT:   state <= EXT_BRK;
                        CODE_BRK:   state <= EXT_BRK;
                        CODE_LEFT:  left_h   <= 1'b0;
                        CODE_RIGHT: right_h  <= 1'b0;
                        CODE_UP:    up_ext_h <= 1'b0;
                        CODE_DOWN:  down_h   <= 1'b0;
                        default:    ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered outputs, one cycle behind the held flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            move_left  <= 1'b0;
            move_right <= 1'b0;
            jump       <= 1'b0;
            crouch     <= 1'b0;
            keys_held  <= 4'b0000;
        end else begin
            move_left  <= left_h  & (~right_h | ~last_right);
            move_right <= right_h & (~left_h  |  last_right);
            jump       <= up_ext_h | up_space_h;
            crouch     <= down_h;
            keys_held  <= {down_h, up_ext_h | up_space_h, right_h, left_h};
        end
    end

endmodule

// File: tb/tb_tom_key_decoder.sv
module tb_tom_key_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       move_left;
  logic       move_right;
  logic       jump;
  logic       crouch;
  logic [3:0] keys_held;

  int checks = 0;
  int errors = 0;

  // Expected word: {move_left, move_right, jump, crouch, keys_held}
  logic [7:0] exp_q[$];
  logic [1:0] vld_pipe;

  tom_key_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .move_left  (move_left),
    .move_right (move_right),
    .jump       (jump),
    .crouch     (crouch),
    .keys_held  (keys_held)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] out_word();
    return {move_left, move_right, jump, crouch, keys_held};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // driver: one byte strobe followed by one idle cycle
  task automatic send(input logic [7:0] b, input logic [7:0] exp);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: outputs reflect a byte one edge after the edge that took it
  always @(posedge clk) begin
    if (rst) vld_pipe <= 2'b00;
    else     vld_pipe <= {vld_pipe[0], rx_valid};
  end

  always @(negedge clk) begin
    if (!rst && vld_pipe[1]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got %02h with no expected entry", out_word());
      end else begin
        check("byte_response", out_word(), exp_q.pop_front());
      end
    end
  end

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_word(), 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", out_word(), 8'h00);

    // left press / release
    send(8'hE0, 8'h00); send(8'h6B, 8'h81);
    send(8'hE0, 8'h81); send(8'hF0, 8'h81); send(8'h6B, 8'h00);

    // left then right: right wins; release right -> left again
    send(8'hE0, 8'h00); send(8'h6B, 8'h81);
    send(8'hE0, 8'h81); send(8'h74, 8'h43);
    send(8'hE0, 8'h43); send(8'hF0, 8'h43); send(8'h74, 8'h81);
    send(8'hE0, 8'h81); send(8'hF0, 8'h81); send(8'h6B, 8'h00);

    // right then left: left wins; typematic right does not steal priority
    send(8'hE0, 8'h00); send(8'h74, 8'h42);
    send(8'hE0, 8'h42); send(8'h6B, 8'h83);
    send(8'hE0, 8'h83); send(8'h74, 8'h83);
    send(8'hE0, 8'h83); send(8'hF0, 8'h83); send(8'h6B, 8'h42);
    send(8'hE0, 8'h42); send(8'hF0, 8'h42); send(8'h74, 8'h00);

    // space and up tracked separately
    send(8'h29, 8'h24);
    send(8'hE0, 8'h24); send(8'h75, 8'h24);
    send(8'hF0, 8'h24); send(8'h29, 8'h24);
    send(8'hE0, 8'h24); send(8'hF0, 8'h24); send(8'h75, 8'h00);

    // keypad codes ignored; spurious break is a no-op
    send(8'h6B, 8'h00);
    send(8'hF0, 8'h00); send(8'h72, 8'h00);
    send(8'hE0, 8'h00); send(8'hF0, 8'h00); send(8'h74, 8'h00);
    // parser must be back in IDLE: a fresh extended make works
    send(8'hE0, 8'h00); send(8'h72, 8'h18);
    send(8'hE0, 8'h18); send(8'hF0, 8'h18); send(8'h72, 8'h00);

    // E0 after F0 turns the sequence into an extended make
    send(8'hF0, 8'h00); send(8'hE0, 8'h00); send(8'h6B, 8'h81);
    send(8'hE0, 8'h81); send(8'hF0, 8'h81); send(8'hF0, 8'h81); send(8'h6B, 8'h00);

    // reset mid-sequence discards the pending E0
    send(8'hE0, 8'h00);
    do_reset();
    check("reset_mid_seq", out_word(), 8'h00);
    send(8'h6B, 8'h00);
    send(8'hE0, 8'h00); send(8'h6B, 8'h81);

    // reset clears held keys
    do_reset();
    check("reset_clears_held", out_word(), 8'h00);
    send(8'hE0, 8'h00); send(8'hF0, 8'h00); send(8'h6B, 8'h00);

`ifdef KEY_TIMEOUT_EN
    begin
      int n;
      send(8'hE0, 8'h00); send(8'h72, 8'h18);
      for (int r = 0; r < 3; r++) begin
        repeat (8) @(negedge clk);
        send(8'hE0, 8'h18); send(8'h72, 8'h18);
      end
      check("crouch_kept_by_repeat", out_word(), 8'h18);
      n = 0;
      while (crouch && n < 40) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (crouch || n < 14 || n > 18) begin
        errors++;
        $display("FAIL timeout_release: crouch %0b after %0d idle cycles, required 0 after 14..18",
                 crouch, n);
      end
      check("timeout_outputs_clear", out_word(), 8'h00);
      send(8'hE0, 8'h00); send(8'h6B, 8'h81);
    end
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
